// File: rtl/dot_product_stream.sv
// Streaming dot-product engine: LANES-wide multiply, registered adder tree, accumulation over VEC_LEN elements.
// Optional result clamping is enabled by defining DP_SATURATE_EN; otherwise the result wraps and sat is 0.
module dot_product_stream #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned PIXEL_SIZE  = 10,
    parameter int unsigned WEIGHT_SIZE = 19,
    parameter int unsigned VEC_LEN     = 785,
    parameter int unsigned FRAC_SHIFT  = 0,
    parameter int unsigned VAL_SIZE    = 26
) (
    input  logic                          clk,
    input  logic                          GlobalReset,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*PIXEL_SIZE-1:0]   Pixels,
    input  logic [LANES*WEIGHT_SIZE-1:0]  Weights,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [VAL_SIZE-1:0]           value,
    output logic                          sat
);

    localparam int unsigned BEATS  = (VEC_LEN + LANES - 1) / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PROD_W = WEIGHT_SIZE + PIXEL_SIZE + 1;
    localparam int unsigned ACC_W  = PROD_W + $clog2(VEC_LEN);
    localparam int unsigned EXT_W  = ((ACC_W > VAL_SIZE) ? ACC_W : VAL_SIZE) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                       state;
    logic [BEAT_W-1:0]            beat;
    logic                         accept;
    logic [LANES-1:0]             lane_live;

    logic                         s0_valid, s0_first, s0_last;
    logic [PIXEL_SIZE-1:0]        s0_pix [LANES];
    logic signed [WEIGHT_SIZE-1:0] s0_wt [LANES];

    logic                         s1_valid, s1_first, s1_last;
    logic signed [PROD_W-1:0]     s1_prod [LANES];
    logic signed [PROD_W-1:0]     wt_ext [LANES];
    logic signed [PROD_W-1:0]     pix_ext [LANES];

    logic                         s2_valid, s2_first, s2_last;
    logic signed [ACC_W-1:0]      s2_sum;
    logic signed [ACC_W-1:0]      tree_c;

    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_next;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [EXT_W-1:0]      ext;
    logic [VAL_SIZE-1:0]          res_c;

    assign accept = in_valid & in_ready;

    // Lanes past the end of the vector on the final beat contribute nothing.
    always_comb begin
        lane_live = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_live[i] = ((32'(beat) * LANES + i) < VEC_LEN);
        end
    end

    // Stage 0: capture the accepted beat with dead lanes zeroed.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s0_pix[i] <= '0;
                s0_wt[i]  <= '0;
            end
        end else if (clear) begin
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_first <= (beat == '0);
                s0_last  <= (beat == LAST_BEAT);
                for (int unsigned i = 0; i < LANES; i++) begin
                    s0_pix[i] <= Pixels[i*PIXEL_SIZE +: PIXEL_SIZE];
                    s0_wt[i]  <= lane_live[i] ? Weights[i*WEIGHT_SIZE +: WEIGHT_SIZE] : '0;
                end
            end
        end
    end

    // Operands widened to the exact product width; pixel is unsigned.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            wt_ext[i]  = PROD_W'(s0_wt[i]);
            pix_ext[i] = PROD_W'({1'b0, s0_pix[i]});
        end
    end

    // Stage 1: lane products.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_first <= s0_first;
                s1_last  <= s0_last;
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_prod[i] <= wt_ext[i] * pix_ext[i];
                end
            end
        end
    end

    always_comb begin
        tree_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            tree_c = tree_c + ACC_W'(s1_prod[i]);
        end
    end

    // Stage 2: registered adder tree.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (clear) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_sum   <= tree_c;
            end
        end
    end

    assign acc_next = s2_first ? s2_sum : (acc + s2_sum);

    // Accumulator: first beat loads, later beats add, emptied on return to IDLE.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (state == HOLD && out_ready) begin
            acc <= '0;
        end else if (s2_valid) begin
            acc <= acc_next;
        end
    end

`ifdef DP_SATURATE_EN
    localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) <<< (VAL_SIZE - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - EXT_W'(1);
    logic sat_c;

    always_comb begin
        shifted = acc_next >>> FRAC_SHIFT;
        ext     = EXT_W'(shifted);
        sat_c   = 1'b0;
        res_c   = VAL_SIZE'(ext);
        if (ext > MAX_V) begin
            res_c = VAL_SIZE'(MAX_V);
            sat_c = 1'b1;
        end else if (ext < MIN_V) begin
            res_c = VAL_SIZE'(MIN_V);
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            sat <= 1'b0;
        end else if (!clear && state == DRAIN && s2_valid && s2_last) begin
            sat <= sat_c;
        end
    end
`else
    always_comb begin
        shifted = acc_next >>> FRAC_SHIFT;
        ext     = EXT_W'(shifted);
        res_c   = VAL_SIZE'(ext);
    end

    assign sat = 1'b0;
`endif

    // Control FSM; in_ready and out_valid are registered copies of the state decode.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state     <= IDLE;
            beat      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            value     <= '0;
        end else if (clear) begin
            state     <= IDLE;
            beat      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (beat == LAST_BEAT) begin
                            state    <= DRAIN;
                            beat     <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                            beat  <= beat + BEAT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (s2_valid && s2_last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        value     <= res_c;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
